spi_ram_ctrl: RTL and testbench
===============================

# spi_ram_ctrl

Parametrised single-port RAM controller on the SPI slave side of the wrapper. It decodes framed command words from the SPI slave (`rx_valid`/`din`) into address-set, write and read operations, and returns read data to the slave for shifting out (`tx_valid`/`dout`). It is the next generation of the fixed 256x8 slave RAM, adding:

- configurable width and depth,
- optional address auto-increment for burst transfers,
- a post-reset memory clear sequence with a `busy` indication.

## Interface
- `DATA_WIDTH`, 8: memory word width; also the payload width of `din`.
- `ADDR_WIDTH`, 8: address width; depth = 2**ADDR_WIDTH; must satisfy ADDR_WIDTH <= DATA_WIDTH.
- `AUTO_INC`, 1: 1 = the active pointer increments after each write/read; 0 = pointers hold.
- `CLEAR_ON_RESET`, 1: 1 = zero all words after reset release; 0 = contents undefined after power-up and untouched by reset.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  `din` holds a command word this cycle (one-cycle strobe per word).
- `din`  in  DATA_WIDTH+2  [DATA_WIDTH+1:DATA_WIDTH] = opcode, [DATA_WIDTH-1:0] = payload.
- `tx_valid`  out  1  `dout` is valid (one-cycle pulse per read).
- `dout`  out  DATA_WIDTH  read data.
- `busy`  out  1  clear sequence in progress; commands are ignored.

## Operation
- Opcode 00, WADDR: `wr_ptr` <= payload[ADDR_WIDTH-1:0]; upper payload bits are ignored.
- Opcode 01, WDATA: mem[`wr_ptr`] <= payload. If AUTO_INC, `wr_ptr` <= `wr_ptr`+1.
- Opcode 10, RADDR: `rd_ptr` <= payload[ADDR_WIDTH-1:0].
- Opcode 11, RDATA: `dout` <= mem[`rd_ptr`] and `tx_valid` pulses. If AUTO_INC, `rd_ptr` <= `rd_ptr`+1. Payload is ignored.
- A command is acted on only when `rx_valid`=1 and `busy`=0. Every opcode, including RDATA, is gated by `rx_valid`.
- Pointers are ADDR_WIDTH bits wide and wrap modulo depth: 2**ADDR_WIDTH-1 + 1 -> 0.
- FSM states:
  - CLEAR: `clr_cnt` walks 0..depth-1, writing 0 to mem[`clr_cnt`] once per cycle; `busy`=1. After the write to depth-1, go to IDLE.
  - IDLE: normal command decoding; `busy`=0.
- Reset entry: CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- Reset values: `tx_valid`=0, `dout`=0, `wr_ptr`=0, `rd_ptr`=0, `clr_cnt`=0, `busy`=CLEAR_ON_RESET.
- Reset asserted mid-CLEAR aborts the sweep; the sweep restarts from address 0 on release.
- Reset does not itself modify mem; only the CLEAR sweep does.
- `rx_valid` words arriving during CLEAR are dropped silently: no pointer or memory change, no `tx_valid`.

## Timing
- Write: with WDATA sampled at edge E, memory is updated at E.
- Read-after-write: RDATA at edge E+1 to the same address returns the new data.
- Read latency is 1 cycle: with RDATA sampled at edge E, `dout` and `tx_valid`=1 are driven from E until edge E+1.
- `tx_valid` drops to 0 at the next edge unless another RDATA is sampled there. Back-to-back RDATA gives continuous `tx_valid`=1 with a new `dout` each cycle.
- `dout` holds its last value when `tx_valid`=0.
- Pointer updates take effect for the command sampled at the next edge. RADDR at E followed by RDATA at E+1 reads the new address.
- CLEAR lasts exactly depth cycles after reset release. `busy` falls at the edge that completes the write to depth-1; a command sampled at the following edge is accepted.
- No backpressure: the slave must tolerate `tx_valid` one cycle after the RDATA strobe.

## Test plan
- Reset release, CLEAR_ON_RESET=1, depth 256: `busy`=1 for 256 cycles, then 0. Afterwards, RADDR 0x00 then 256 RDATA -> 256 `tx_valid` pulses, all `dout`=0x00.
- WADDR 0x10, WDATA 0xA5, RADDR 0x10, RDATA on consecutive cycles -> `tx_valid`=1 exactly one cycle after the RDATA strobe with `dout`=0xA5; `tx_valid`=0 on the next cycle.
- AUTO_INC=1: WADDR 0xFE, WDATA 0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap). RADDR 0xFE plus three back-to-back RDATA -> `dout` 0x11, 0x22, 0x33 with `tx_valid` high three consecutive cycles.
- Opcode 11 on `din` with `rx_valid`=0 -> no `tx_valid` and `rd_ptr` unchanged. WDATA during `busy`=1 -> dropped, word still 0 after the clear.
- Reset pulsed at clear cycle 100 -> `busy` stays 1, and the sweep restarts to take a full 256 cycles after release. Mid-IDLE reset -> `tx_valid`=0, `dout`=0 immediately (asynchronous), pointers back to 0.
- DATA_WIDTH=16, ADDR_WIDTH=4, AUTO_INC=0: WADDR 0x00F3 uses address 0x3. WDATA 0xBEEF twice, then RDATA twice -> mem[3]=0xBEEF and `dout`=0xBEEF on both reads.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: SPI-slave-side RAM controller decoding framed command words into
// address-set / write / read operations, with optional pointer auto-increment and
// a post-reset memory clear sweep.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   rx_valid in   din holds a command word this cycle
//   din      in   [DATA_WIDTH+1:DATA_WIDTH] opcode, [DATA_WIDTH-1:0] payload
//   tx_valid out  one-cycle pulse per read, dout valid
//   dout     out  read data, held while tx_valid=0
//   busy     out  clear sweep in progress, commands dropped
module spi_ram_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter bit AUTO_INC       = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] din,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    clearing, cmd_ok;
    logic [1:0]              op;
    logic                    is_waddr, is_wdata, is_raddr, is_rdata;

    always_comb begin
        clearing  = state_q == S_CLEAR;
        cmd_ok    = rx_valid && state_q == S_IDLE;
        op        = din[DATA_WIDTH+:2];
        is_waddr  = cmd_ok && op == 2'b00;
        is_wdata  = cmd_ok && op == 2'b01;
        is_raddr  = cmd_ok && op == 2'b10;
        is_rdata  = cmd_ok && op == 2'b11;
        wr_ptr_d  = is_waddr ? din[ADDR_WIDTH-1:0] :
                    (is_wdata && AUTO_INC) ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = is_raddr ? din[ADDR_WIDTH-1:0] :
                    (is_rdata && AUTO_INC) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // Counter wraps back to 0 after depth-1, ready for the next sweep.
        clr_cnt_d = clearing ? clr_cnt_q + 1'b1 : clr_cnt_q;
        state_d   = (clearing && clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) ? S_IDLE : state_q;
        busy_d    = state_d == S_CLEAR;
        tx_valid_d = is_rdata;
        dout_d    = is_rdata ? mem[rd_ptr_q] : dout_q;
        // Hold off the sweep write while reset is held so reset alone never touches mem.
        mem_we    = (clearing && !rst) || is_wdata;
        mem_addr  = clearing ? clr_cnt_q : wr_ptr_q;
        mem_wdata = clearing ? '0 : din[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            clr_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
            dout_q     <= '0;
            busy_q     <= CLEAR_ON_RESET;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            clr_cnt_q  <= clr_cnt_d;
            tx_valid_q <= tx_valid_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign tx_valid = tx_valid_q;
    assign dout     = dout_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed self-checking bench for spi_ram_ctrl (8x256 auto-inc and 16x16 hold variants)
module tb_spi_ram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx0 = 1'b0, rx1 = 1'b0;
    logic [9:0]  din0 = '0;
    logic [17:0] din1 = '0;
    logic        tx0, tx1, busy0, busy1;
    logic [7:0]  dout0;
    logic [15:0] dout1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1'b1), .CLEAR_ON_RESET(1'b1)) u0 (
        .clk(clk), .rst(rst), .rx_valid(rx0), .din(din0),
        .tx_valid(tx0), .dout(dout0), .busy(busy0));

    spi_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AUTO_INC(1'b0), .CLEAR_ON_RESET(1'b1)) u1 (
        .clk(clk), .rst(rst), .rx_valid(rx1), .din(din1),
        .tx_valid(tx1), .dout(dout1), .busy(busy1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one word at a falling edge; outputs seen after the next call reflect it.
    task automatic cmd(input int u, input logic v, input logic [1:0] op, input logic [15:0] pl);
        @(negedge clk);
        rx0 = 1'b0;
        rx1 = 1'b0;
        if (u == 0) begin
            rx0 = v;
            din0 = {op, pl[7:0]};
        end else begin
            rx1 = v;
            din1 = {op, pl};
        end
    endtask

    task automatic nop();
        cmd(0, 1'b0, 2'b00, 16'h0);
    endtask

    // Counts cycles until busy falls, injecting a WDATA and an RDATA to unit 0 mid-sweep.
    task automatic count_busy(output int n0, output int n1, output int tx_seen);
        n0 = 0;
        n1 = -1;
        tx_seen = 0;
        while (busy0 && n0 < 400) begin
            @(negedge clk);
            n0++;
            if (tx0) tx_seen++;
            if (!busy1 && n1 < 0) n1 = n0;
            rx0  = (n0 == 50 || n0 == 60);
            din0 = (n0 == 50) ? {2'b01, 8'h77} : {2'b11, 8'h00};
        end
        rx0 = 1'b0;
    endtask

    initial begin
        int n0, n1, txs, bad;
        #12;
        chk("rst_tx", tx0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_busy0", busy0, 1);
        chk("rst_busy1", busy1, 1);
        @(negedge clk);
        rst = 1'b0;
        count_busy(n0, n1, txs);
        chk("clear_len0", n0, 256);
        chk("clear_len1", n1, 16);
        chk("busy_no_tx", txs, 0);

        // full read-back of cleared memory; mem[0] also proves the busy WDATA was dropped
        cmd(0, 1, 2'b10, 16'h00);
        bad = 0;
        for (int i = 0; i < 257; i++) begin
            if (i < 256) cmd(0, 1, 2'b11, 16'h0); else nop();
            if (i > 0 && (tx0 !== 1'b1 || dout0 !== 8'h00)) bad++;
        end
        chk("clear_reads_bad", bad, 0);
        nop();
        chk("tx_drop_after_burst", tx0, 0);

        // write then read at 0x10
        cmd(0, 1, 2'b00, 16'h10);
        cmd(0, 1, 2'b01, 16'hA5);
        cmd(0, 1, 2'b10, 16'h10);
        cmd(0, 1, 2'b11, 16'h0);
        nop();
        chk("rd10_tx", tx0, 1);
        chk("rd10_dout", dout0, 8'hA5);
        nop();
        chk("rd10_tx_low", tx0, 0);
        chk("rd10_dout_hold", dout0, 8'hA5);

        // auto-increment with wrap
        cmd(0, 1, 2'b00, 16'hFE);
        cmd(0, 1, 2'b01, 16'h11);
        cmd(0, 1, 2'b01, 16'h22);
        cmd(0, 1, 2'b01, 16'h33);
        cmd(0, 1, 2'b10, 16'hFE);
        cmd(0, 1, 2'b11, 16'h0);
        cmd(0, 1, 2'b11, 16'h0);
        chk("burst0_tx", tx0, 1);
        chk("burst0_dout", dout0, 8'h11);
        cmd(0, 1, 2'b11, 16'h0);
        chk("burst1_tx", tx0, 1);
        chk("burst1_dout", dout0, 8'h22);
        nop();
        chk("burst2_tx", tx0, 1);
        chk("burst2_dout", dout0, 8'h33);
        nop();
        chk("burst_end_tx", tx0, 0);

        // RDATA opcode without rx_valid is ignored
        cmd(0, 1, 2'b10, 16'h10);
        cmd(0, 0, 2'b11, 16'h0);
        nop();
        chk("novalid_tx", tx0, 0);
        cmd(0, 1, 2'b11, 16'h0);
        nop();
        chk("novalid_rdptr", dout0, 8'hA5);
        chk("novalid_rd_tx", tx0, 1);

        // asynchronous reset in IDLE
        #2 rst = 1'b1;
        #1;
        chk("async_tx", tx0, 0);
        chk("async_dout", dout0, 0);
        chk("async_busy", busy0, 1);
        @(negedge clk);
        rst = 1'b0;
        count_busy(n0, n1, txs);
        chk("reclear_len", n0, 256);
        cmd(0, 1, 2'b01, 16'h5A);
        cmd(0, 1, 2'b11, 16'h0);
        nop();
        chk("ptrs_zero_raw", dout0, 8'h5A);
        cmd(0, 1, 2'b10, 16'h10);
        cmd(0, 1, 2'b11, 16'h0);
        nop();
        chk("recleared_10", dout0, 8'h00);

        // reset pulse in the middle of a sweep
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("midclr_busy_before", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midclr_busy_rst", busy0, 1);
        rst = 1'b0;
        count_busy(n0, n1, txs);
        chk("midclr_len", n0, 256);

        // 16-bit, 16-deep, no auto-increment
        cmd(1, 1, 2'b00, 16'h00F3);
        cmd(1, 1, 2'b01, 16'hBEEF);
        cmd(1, 1, 2'b01, 16'hBEEF);
        cmd(1, 1, 2'b10, 16'h0003);
        cmd(1, 1, 2'b11, 16'h0);
        cmd(1, 1, 2'b11, 16'h0);
        chk("w16_rd0_tx", tx1, 1);
        chk("w16_rd0", dout1, 16'hBEEF);
        cmd(1, 1, 2'b10, 16'h0004);
        chk("w16_rd1_tx", tx1, 1);
        chk("w16_rd1", dout1, 16'hBEEF);
        cmd(1, 1, 2'b11, 16'h0);
        chk("w16_raddr_tx", tx1, 0);
        nop();
        chk("w16_addr4", dout1, 16'h0000);
        chk("w16_addr4_tx", tx1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
